// File: rtl/pixel_window_ctrl.sv
// Region-of-interest capture controller: arms on request, captures one full frame inside a
// programmable window, passes or blanks pixels, counts in-window pixels. Macro: ROI_DIM_EN.
module pixel_window_ctrl #(
    parameter int CW = 16,
    parameter int PW = 8
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    input  logic [CW-1:0] h_cont,
    input  logic [CW-1:0] v_cont,
    input  logic [PW-1:0] red_in,
    input  logic [PW-1:0] green_in,
    input  logic [PW-1:0] blue_in,
    output logic [PW-1:0] red_out,
    output logic [PW-1:0] green_out,
    output logic [PW-1:0] blue_out,
    input  logic          cfg_wr,
    input  logic [1:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    input  logic          arm,
    input  logic          ack,
    output logic          busy,
    output logic          done,
    output logic          win_valid,
    output logic [23:0]   pix_count
);
    // state   | meaning
    // IDLE    | waiting for arm
    // ARMED   | waiting for the next frame start
    // CAPTURE | counting/filtering one full frame
    // DONE    | frame captured, waiting for ack
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t        state;
    logic [CW-1:0] x0, x1, y0, y1;
    logic [CW-1:0] h_prev, v_prev;
    logic          fs;
    logic          in_win;
    logic          capturing;
    logic [PW-1:0] red_oow, green_oow, blue_oow;

    // A counter stalled at (0,0) yields only one frame start.
    assign fs        = (h_cont == '0) && (v_cont == '0) && !((h_prev == '0) && (v_prev == '0));
    assign in_win    = (h_cont >= x0) && (h_cont <= x1) && (v_cont >= y0) && (v_cont <= y1);
    assign capturing = (state == CAPTURE);

`ifdef ROI_DIM_EN
    assign red_oow   = red_in >> 1;
    assign green_oow = green_in >> 1;
    assign blue_oow  = blue_in >> 1;
`else
    assign red_oow   = '0;
    assign green_oow = '0;
    assign blue_oow  = '0;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            h_prev <= '0;
            v_prev <= '0;
        end else begin
            h_prev <= h_cont;
            v_prev <= v_cont;
        end
    end

    // Window registers are frozen while a frame is being captured.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            x0 <= '0;
            x1 <= '1;
            y0 <= '0;
            y1 <= '1;
        end else if (cfg_wr && !capturing) begin
            case (cfg_addr)
                2'd0:    x0 <= cfg_wdata;
                2'd1:    x1 <= cfg_wdata;
                2'd2:    y0 <= cfg_wdata;
                default: y1 <= cfg_wdata;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (fs) begin
                        state     <= CAPTURE;
                        pix_count <= '0;
                    end
                end
                CAPTURE: begin
                    if (in_win && (pix_count != 24'hFFFFFF))
                        pix_count <= pix_count + 24'd1;
                    if (fs) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= capturing && in_win;
            if (capturing && !in_win) begin
                red_out   <= red_oow;
                green_out <= green_oow;
                blue_out  <= blue_oow;
            end else begin
                red_out   <= red_in;
                green_out <= green_in;
                blue_out  <= blue_in;
            end
        end
    end
endmodule
